// File: rtl/nlb_req_arb.sv
// Two-requester arbiter for the NLB read and write request channels: round-robin
// grants, outstanding-request credit limits, requester tagging and response routing.
`timescale 1ns/1ps

// One request channel: grant logic, pending counter, issue register and response router.
module nlb_req_arb_chan #(
   parameter int ADDR_W   = 20,
   parameter int PEND_MAX = 256,
   parameter int CNT_W    = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            en_i,
   input  logic [2*ADDR_W-1:0]   addr_i,
   input  logic [31:0]           tid_i,
   input  logic                  alm_full_i,
   input  logic                  rsp_valid_i,
   input  logic [16:0]           rsp_tid_i,
   output logic [1:0]            sent_o,
   output logic                  tx_valid_o,
   output logic [ADDR_W-1:0]     tx_addr_o,
   output logic [16:0]           tx_tid_o,
   output logic [1:0]            rsp_valid_o,
   output logic [15:0]           rsp_tid_o,
   output logic [CNT_W-1:0]      pend_o,
   output logic                  err_o
);

   localparam logic [CNT_W-1:0] PEND_LIM = CNT_W'(PEND_MAX);

   logic              ok;
   logic              gnt;
   logic              gnt_id;

   logic              ptr_q,       ptr_d;
   logic [CNT_W-1:0]  pend_q,      pend_d;
   logic              err_q,       err_d;
   logic              tx_valid_q;
   logic [ADDR_W-1:0] tx_addr_q,   tx_addr_d;
   logic [16:0]       tx_tid_q,    tx_tid_d;
   logic [1:0]        rsp_valid_q, rsp_valid_d;
   logic [15:0]       rsp_tid_q,   rsp_tid_d;

   // NOTE: rst_n gates the grant so Sent drops the moment reset asserts, not at the next edge.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      gnt    = 1'b0;
      gnt_id = 1'b0;
      ok     = !alm_full_i && (pend_q < PEND_LIM);
      if (rst_n && ok) begin
         case (en_i)
            2'b01:   begin gnt = 1'b1; gnt_id = 1'b0;  end
            2'b10:   begin gnt = 1'b1; gnt_id = 1'b1;  end
            2'b11:   begin gnt = 1'b1; gnt_id = ptr_q; end
            default: ;
         endcase
      end
      sent_o = {gnt & gnt_id, gnt & ~gnt_id};
   end

   always_comb begin
      ptr_d       = gnt ? ~gnt_id : ptr_q;
      pend_d      = pend_q;
      err_d       = err_q;
      tx_addr_d   = tx_addr_q;
      tx_tid_d    = tx_tid_q;
      rsp_valid_d = 2'b00;
      rsp_tid_d   = rsp_tid_q;

      // A grant and a response in the same cycle cancel out.
      case ({gnt, rsp_valid_i})
         2'b10:   pend_d = pend_q + CNT_W'(1);
         2'b01:   if (pend_q != '0) pend_d = pend_q - CNT_W'(1);
         default: ;
      endcase
      if (rsp_valid_i && (pend_q == '0)) err_d = 1'b1;

      if (gnt) begin
         tx_addr_d = gnt_id ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
         tx_tid_d  = {gnt_id, gnt_id ? tid_i[31:16] : tid_i[15:0]};
      end

      if (rsp_valid_i) begin
         rsp_valid_d = rsp_tid_i[16] ? 2'b10 : 2'b01;
         rsp_tid_d   = rsp_tid_i[15:0];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= 1'b0;
         pend_q      <= '0;
         err_q       <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_addr_q   <= '0;
         tx_tid_q    <= '0;
         rsp_valid_q <= 2'b00;
         rsp_tid_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         pend_q      <= pend_d;
         err_q       <= err_d;
         tx_valid_q  <= gnt;
         tx_addr_q   <= tx_addr_d;
         tx_tid_q    <= tx_tid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tid_q   <= rsp_tid_d;
      end
   end

   assign tx_valid_o  = tx_valid_q;
   assign tx_addr_o   = tx_addr_q;
   assign tx_tid_o    = tx_tid_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_tid_o   = rsp_tid_q;
   assign pend_o      = pend_q;
   assign err_o       = err_q;

endmodule

module nlb_req_arb #(
   parameter int ADDR_LMT    = 20,
   parameter int RD_PEND_MAX = 256,
   parameter int WR_PEND_MAX = 256,
   parameter int CNT_W       = 10
) (
   input  logic                    Clk_400,
   input  logic                    test_Resetb,

   input  logic [1:0]              req_RdEn,
   input  logic [2*ADDR_LMT-1:0]   req_RdAddr,
   input  logic [31:0]             req_RdTID,
   output logic [1:0]              req_RdSent,

   input  logic [1:0]              req_WrEn,
   input  logic [2*ADDR_LMT-1:0]   req_WrAddr,
   input  logic [31:0]             req_WrTID,
   input  logic [1023:0]           req_WrDin,
   output logic [1:0]              req_WrSent,

   output logic                    tx_RdValid,
   output logic [ADDR_LMT-1:0]     tx_RdAddr,
   output logic [16:0]             tx_RdTID,
   input  logic                    tx_RdAlmFull,

   output logic                    tx_WrValid,
   output logic [ADDR_LMT-1:0]     tx_WrAddr,
   output logic [16:0]             tx_WrTID,
   output logic [511:0]            tx_WrDin,
   input  logic                    tx_WrAlmFull,

   input  logic                    rx_RdRspValid,
   input  logic [16:0]             rx_RdRspTID,
   input  logic [511:0]            rx_RdData,
   input  logic                    rx_WrRspValid,
   input  logic [16:0]             rx_WrRspTID,

   output logic [1:0]              rsp_RdValid,
   output logic [15:0]             rsp_RdTID,
   output logic [511:0]            rsp_RdData,
   output logic [1:0]              rsp_WrValid,
   output logic [15:0]             rsp_WrTID,

   output logic [CNT_W-1:0]        rd_pend,
   output logic [CNT_W-1:0]        wr_pend,
   output logic                    pend_err
);

   logic         rd_err;
   logic         wr_err;
   logic [511:0] wr_din_q, wr_din_d;
   logic [511:0] rd_data_q, rd_data_d;

   nlb_req_arb_chan #(
      .ADDR_W   (ADDR_LMT),
      .PEND_MAX (RD_PEND_MAX),
      .CNT_W    (CNT_W)
   ) u_rd_chan (
      .clk         (Clk_400),
      .rst_n       (test_Resetb),
      .en_i        (req_RdEn),
      .addr_i      (req_RdAddr),
      .tid_i       (req_RdTID),
      .alm_full_i  (tx_RdAlmFull),
      .rsp_valid_i (rx_RdRspValid),
      .rsp_tid_i   (rx_RdRspTID),
      .sent_o      (req_RdSent),
      .tx_valid_o  (tx_RdValid),
      .tx_addr_o   (tx_RdAddr),
      .tx_tid_o    (tx_RdTID),
      .rsp_valid_o (rsp_RdValid),
      .rsp_tid_o   (rsp_RdTID),
      .pend_o      (rd_pend),
      .err_o       (rd_err)
   );

   nlb_req_arb_chan #(
      .ADDR_W   (ADDR_LMT),
      .PEND_MAX (WR_PEND_MAX),
      .CNT_W    (CNT_W)
   ) u_wr_chan (
      .clk         (Clk_400),
      .rst_n       (test_Resetb),
      .en_i        (req_WrEn),
      .addr_i      (req_WrAddr),
      .tid_i       (req_WrTID),
      .alm_full_i  (tx_WrAlmFull),
      .rsp_valid_i (rx_WrRspValid),
      .rsp_tid_i   (rx_WrRspTID),
      .sent_o      (req_WrSent),
      .tx_valid_o  (tx_WrValid),
      .tx_addr_o   (tx_WrAddr),
      .tx_tid_o    (tx_WrTID),
      .rsp_valid_o (rsp_WrValid),
      .rsp_tid_o   (rsp_WrTID),
      .pend_o      (wr_pend),
      .err_o       (wr_err)
   );

   // Wide payloads ride alongside the channel: write data follows the write grant,
   // read data follows the read response.
   always_comb begin
      wr_din_d = wr_din_q;
      if (req_WrSent[1])      wr_din_d = req_WrDin[1023:512];
      else if (req_WrSent[0]) wr_din_d = req_WrDin[511:0];
      rd_data_d = rx_RdRspValid ? rx_RdData : rd_data_q;
   end

   always_ff @(posedge Clk_400 or negedge test_Resetb) begin
      if (!test_Resetb) begin
         wr_din_q  <= '0;
         rd_data_q <= '0;
      end else begin
         wr_din_q  <= wr_din_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign tx_WrDin   = wr_din_q;
   assign rsp_RdData = rd_data_q;
   assign pend_err   = rd_err | wr_err;

endmodule
